// File: rtl/lfsr_prbs_gen_chk.sv
// lfsr_prbs_gen_chk: Fibonacci-style PRBS generator plus a self-synchronising
// PRBS checker with a SEARCH / VERIFY / LOCKED acquisition FSM and a
// saturating error counter.
// Optional feature macro: LFSR_PRBS_ERRINJ_EN adds the InjErr input, which
// inverts the emitted generator bit without disturbing the LFSR state.
module lfsr_prbs_gen_chk #(
  parameter int                WIDTH    = 31,
  parameter logic [WIDTH-1:0]  TAP_MASK = 31'h4800_0000,
  parameter int                ERRCNT_W = 16,
  parameter int                LOCK_CNT = 64,
  parameter int                LOSS_CNT = 8
) (
  input  logic                Clk,
  input  logic                ARst,
  input  logic                En,
  input  logic                SeedLoad,
  input  logic [WIDTH-1:0]    Seed,
  output logic                GenOut,
  input  logic                ChkEn,
  input  logic                ChkIn,
  input  logic                ErrClr,
  output logic                Locked,
  output logic                ErrPulse,
  output logic [ERRCNT_W-1:0] ErrCnt
`ifdef LFSR_PRBS_ERRINJ_EN
  ,
  input  logic                InjErr
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Fill count only needs to reach WIDTH-1 (max 31); match/loss counters up to 254.
  localparam int FILL_W = 6;
  localparam int CNT_W  = 8;

  // Parity of the tapped bits: the next LFSR bit for a given register image.
  function automatic logic tap_parity(input logic [WIDTH-1:0] sr);
    return ^(sr & TAP_MASK);
  endfunction

  logic [WIDTH-1:0]    gen_state_r;
  logic                gen_fb_s;
  logic                gen_bit_s;

  logic [WIDTH-1:0]    chk_sr_r;
  logic                pred_s;
  logic                mism_s;
  logic                sr_zero_s;

  chk_state_t          state_r, state_s;
  logic [FILL_W-1:0]   fill_cnt_r, fill_cnt_s;
  logic [CNT_W-1:0]    match_cnt_r, match_cnt_s;
  logic [CNT_W-1:0]    loss_cnt_r, loss_cnt_s;
  logic                err_hit_s;

  assign gen_fb_s  = tap_parity(gen_state_r);
`ifdef LFSR_PRBS_ERRINJ_EN
  assign gen_bit_s = gen_fb_s ^ InjErr;
`else
  assign gen_bit_s = gen_fb_s;
`endif

  assign pred_s    = tap_parity(chk_sr_r);
  assign mism_s    = ChkIn ^ pred_s;
  assign sr_zero_s = (chk_sr_r == {WIDTH{1'b0}});

  // Generator: seed load has priority over advance; a zero seed becomes all-ones.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      gen_state_r <= {WIDTH{1'b1}};
      GenOut      <= 1'b0;
    end else if (SeedLoad) begin
      gen_state_r <= (Seed == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : Seed;
    end else if (En) begin
      gen_state_r <= {gen_state_r[WIDTH-2:0], gen_fb_s};
      GenOut      <= gen_bit_s;
    end
  end

  // Checker shift register: captures the received stream on every valid sample.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      chk_sr_r <= {WIDTH{1'b0}};
    end else if (ChkEn) begin
      chk_sr_r <= {chk_sr_r[WIDTH-2:0], ChkIn};
    end
  end

  // Acquisition FSM next-state and counter updates; idle when ChkEn is low.
  always_comb begin
    state_s     = state_r;
    fill_cnt_s  = fill_cnt_r;
    match_cnt_s = match_cnt_r;
    loss_cnt_s  = loss_cnt_r;
    err_hit_s   = 1'b0;
    if (ChkEn) begin
      case (state_r)
        SEARCH: begin
          if (fill_cnt_r == FILL_W'(WIDTH - 1)) begin
            state_s     = VERIFY;
            fill_cnt_s  = {FILL_W{1'b0}};
            match_cnt_s = {CNT_W{1'b0}};
          end else begin
            fill_cnt_s = fill_cnt_r + 6'd1;
          end
        end
        VERIFY: begin
          // An all-zero register predicts zero forever, so it can never prove lock.
          if (mism_s || sr_zero_s) begin
            state_s     = SEARCH;
            fill_cnt_s  = {FILL_W{1'b0}};
            match_cnt_s = {CNT_W{1'b0}};
          end else if (match_cnt_r == CNT_W'(LOCK_CNT - 1)) begin
            state_s     = LOCKED;
            match_cnt_s = {CNT_W{1'b0}};
            loss_cnt_s  = {CNT_W{1'b0}};
          end else begin
            match_cnt_s = match_cnt_r + 8'd1;
          end
        end
        LOCKED: begin
          if (mism_s) begin
            err_hit_s = 1'b1;
            if (loss_cnt_r == CNT_W'(LOSS_CNT - 1)) begin
              state_s    = SEARCH;
              fill_cnt_s = {FILL_W{1'b0}};
              loss_cnt_s = {CNT_W{1'b0}};
            end else begin
              loss_cnt_s = loss_cnt_r + 8'd1;
            end
          end else begin
            loss_cnt_s = {CNT_W{1'b0}};
          end
        end
        default: begin
          state_s     = SEARCH;
          fill_cnt_s  = {FILL_W{1'b0}};
          match_cnt_s = {CNT_W{1'b0}};
          loss_cnt_s  = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      state_r     <= SEARCH;
      fill_cnt_r  <= {FILL_W{1'b0}};
      match_cnt_r <= {CNT_W{1'b0}};
      loss_cnt_r  <= {CNT_W{1'b0}};
      Locked      <= 1'b0;
      ErrPulse    <= 1'b0;
    end else begin
      state_r     <= state_s;
      fill_cnt_r  <= fill_cnt_s;
      match_cnt_r <= match_cnt_s;
      loss_cnt_r  <= loss_cnt_s;
      Locked      <= (state_s == LOCKED);
      ErrPulse    <= err_hit_s;
    end
  end

  // Error counter: saturates at all-ones, clear wins over a same-cycle increment.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      ErrCnt <= {ERRCNT_W{1'b0}};
    end else if (ErrClr) begin
      ErrCnt <= {ERRCNT_W{1'b0}};
    end else if (err_hit_s && (ErrCnt != {ERRCNT_W{1'b1}})) begin
      ErrCnt <= ErrCnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_gen_chk.sv
// Self-checking bench for lfsr_prbs_gen_chk (WIDTH=7, x^7+x^6+1).
// Generator output is scoreboarded every cycle against a bench model; the
// checker is exercised in loopback with bench-side bit flips and forcing.
module tb_lfsr_prbs_gen_chk;

  localparam int         W    = 7;
  localparam logic [6:0] TAP  = 7'h60;
  localparam int         LOCK = 16;
  localparam int         LOSS = 4;
  localparam int         EW   = 8;

  logic          clk = 1'b0;
  logic          arst, en, seed_load, chk_en, err_clr, inj_err;
  logic [W-1:0]  seed;
  logic          gen_out, locked, err_pulse;
  logic [EW-1:0] err_cnt;
  logic          force0, flip;
  logic          chk_in;

  assign chk_in = force0 ? 1'b0 : (gen_out ^ flip);

  always #5 clk = ~clk;

  lfsr_prbs_gen_chk #(
    .WIDTH(W), .TAP_MASK(TAP), .ERRCNT_W(EW), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)
  ) dut (
    .Clk(clk), .ARst(arst), .En(en), .SeedLoad(seed_load), .Seed(seed),
    .GenOut(gen_out), .ChkEn(chk_en), .ChkIn(chk_in), .ErrClr(err_clr),
    .Locked(locked), .ErrPulse(err_pulse), .ErrCnt(err_cnt)
`ifdef LFSR_PRBS_ERRINJ_EN
    , .InjErr(inj_err)
`endif
  );

  int checks;
  int failures;
  int pulses;
  logic [W-1:0] m_state;
  logic         m_out;
  logic         exp_q[$];
  logic         ref_bits[10];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tapx(input logic [W-1:0] s);
    return ^(s & TAP);
  endfunction

  // Count error strobes once per cycle, away from the active edge.
  always @(negedge clk) if (err_pulse === 1'b1) pulses++;

  // One clock: predict GenOut, push it, clock the DUT, pop and compare.
  task automatic tick();
    logic b;
    logic inj;
    logic e;
`ifdef LFSR_PRBS_ERRINJ_EN
    inj = inj_err;
`else
    inj = 1'b0;
`endif
    if (seed_load) begin
      m_state = (seed == 7'h00) ? 7'h7F : seed;
    end else if (en) begin
      b       = tapx(m_state);
      m_state = {m_state[W-2:0], b};
      m_out   = b ^ inj;
    end
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("gen_out", {31'd0, gen_out}, {31'd0, e});
    end
  endtask

  // Start the generator, then loop it back one cycle later and time the lock.
  task automatic acquire();
    int ones;
    ones   = 0;
    en     = 1'b1;
    chk_en = 1'b0;
    pulses = 0;
    tick();
    ref_bits[0] = gen_out;
    ones += int'(gen_out);
    chk_en = 1'b1;
    for (int n = 1; n <= 126; n++) begin
      tick();
      if (n < 10) ref_bits[n] = gen_out;
      ones += int'(gen_out);
      if (n == 22) check_eq("locked_before_23", {31'd0, locked}, 32'd0);
      if (n == 23) check_eq("locked_at_23", {31'd0, locked}, 32'd1);
    end
    check_eq("ones_per_period", ones, 64);
    check_eq("state_period", {25'd0, dut.gen_state_r}, 32'h7F);
    check_eq("no_pulse_acquire", pulses, 0);
  endtask

  task automatic single_error();
`ifdef LFSR_PRBS_ERRINJ_EN
    inj_err = 1'b1;
    tick();
    inj_err = 1'b0;
`else
    flip = 1'b1;
    tick();
    flip = 1'b0;
`endif
  endtask

  initial begin
    logic w;
    logic [W-1:0] s;
    logic b;
    logic g_before;
    logic relocked;
    int   tries;
    checks = 0; failures = 0; pulses = 0;
    arst = 1'b1; en = 1'b0; seed_load = 1'b0; seed = 7'h00; chk_en = 1'b0;
    err_clr = 1'b0; inj_err = 1'b0; force0 = 1'b0; flip = 1'b0;
    m_state = 7'h7F; m_out = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gen_out", {31'd0, gen_out}, 32'd0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_eq("rst_state", {25'd0, dut.gen_state_r}, 32'h7F);
    @(negedge clk);
    arst = 1'b0;

    acquire();

    // Long clean loopback run.
    pulses = 0;
    repeat (1000) tick();
    check_eq("clean_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_eq("clean_locked", {31'd0, locked}, 32'd1);
    check_eq("clean_pulses", pulses, 0);

    // Enables low: generator and checker hold.
    en = 1'b0; chk_en = 1'b0;
    repeat (5) tick();
    check_eq("hold_state", {25'd0, dut.gen_state_r}, {25'd0, m_state});
    check_eq("hold_locked", {31'd0, locked}, 32'd1);
    en = 1'b1; chk_en = 1'b1;
    repeat (3) tick();

    // One bit error: the flip plus two tap echoes.
    pulses = 0;
    single_error();
    repeat (10) tick();
    check_eq("flip_pulses", pulses, 3);
    check_eq("flip_err_cnt", {24'd0, err_cnt}, 32'd3);
    check_eq("flip_locked", {31'd0, locked}, 32'd1);

    // Drive the counter to saturation with spaced flips (3 errors each).
    for (int i = 0; i < 84; i++) begin
      flip = 1'b1; tick(); flip = 1'b0;
      repeat (7) tick();
    end
    check_eq("sat_err_cnt", {24'd0, err_cnt}, 32'hFF);
    check_eq("sat_locked", {31'd0, locked}, 32'd1);
    pulses = 0;
    flip = 1'b1; tick(); flip = 1'b0;
    repeat (7) tick();
    check_eq("sat_hold", {24'd0, err_cnt}, 32'hFF);
    check_eq("sat_pulses", pulses, 3);
    flip = 1'b1; err_clr = 1'b1; tick(); flip = 1'b0; err_clr = 1'b0;
    check_eq("clr_wins", {24'd0, err_cnt}, 32'd0);
    repeat (7) tick();
    check_eq("clr_echoes", {24'd0, err_cnt}, 32'd2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check_eq("clr_plain", {24'd0, err_cnt}, 32'd0);

    // Wait until the next four stream bits are ones, then force the input low.
    tries = 0;
    w = 1'b0;
    while (!w && tries < 300) begin
      s = m_state;
      w = m_out;
      for (int k = 0; k < 3; k++) begin
        b = tapx(s);
        s = {s[W-2:0], b};
        w = w & b;
      end
      if (!w) tick();
      tries++;
    end
    check_eq("window_found", {31'd0, w}, 32'd1);
    force0 = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("loss_locked", {31'd0, locked}, (k < 4) ? 32'd1 : 32'd0);
    end
    relocked = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (locked) relocked = 1'b1;
    end
    check_eq("zero_no_relock", {31'd0, relocked}, 32'd0);
    check_eq("loss_err_cnt", {24'd0, err_cnt}, 32'd4);
    check_eq("loss_pulses", pulses, 4);
    force0 = 1'b0;
    repeat (60) tick();
    check_eq("relock", {31'd0, locked}, 32'd1);

    // Zero seed loads all-ones; the load cycle does not advance.
    g_before  = gen_out;
    seed      = 7'h00;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check_eq("load_no_adv", {31'd0, gen_out}, {31'd0, g_before});
    check_eq("seed0_state", {25'd0, dut.gen_state_r}, 32'h7F);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("seed0_seq", {31'd0, gen_out}, {31'd0, ref_bits[i]});
    end
    repeat (60) tick();
    check_eq("locked_pre_rst", {31'd0, locked}, 32'd1);

    // Asynchronous reset while locked, then a fresh acquisition.
    @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    check_eq("arst_locked", {31'd0, locked}, 32'd0);
    check_eq("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_eq("arst_gen_out", {31'd0, gen_out}, 32'd0);
    m_state = 7'h7F; m_out = 1'b0;
    exp_q.delete();
    en = 1'b0; chk_en = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    acquire();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
